// File: rtl/i2c_led_pkg.sv
// Shared definitions for the I2C LED PWM register bank: register map
// addresses, CTRL bit positions and the register handshake state type.
package i2c_led_pkg;

  localparam logic [6:0] ADDR_ID        = 7'h00;
  localparam logic [6:0] ADDR_CTRL      = 7'h01;
  localparam logic [6:0] ADDR_CAPS      = 7'h02;
  localparam logic [6:0] ADDR_PRESCALE  = 7'h03;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

  localparam int CTRL_ENABLE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACK          = 2'd1,
    WAIT_RELEASE = 2'd2
  } hs_state_t;

endpackage

// File: rtl/i2c_led_pwm_regs_core.sv
// PWM engine: prescaler, shared PWM counter, shadow/active duty registers,
// per-channel comparators and registered, polarity-adjusted LED outputs.
module led_pwm_core #(
  parameter int NUM_CHANNELS      = 3,
  parameter int PWM_WIDTH         = 8,
  parameter int OUTPUT_ACTIVE_LOW = 1
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              enable_i,
  input  logic [7:0]                        prescale_i,
  input  logic                              prescale_wr_i,
  input  logic                              duty_wr_i,
  input  logic [3:0]                        duty_idx_i,
  input  logic [PWM_WIDTH-1:0]              duty_data_i,
  output logic [NUM_CHANNELS*PWM_WIDTH-1:0] shadow_o,
  output logic [NUM_CHANNELS-1:0]           led_o
);

  // Last counter value before wrap: 2^PWM_WIDTH-2, so a full-scale duty is always lit.
  localparam logic [PWM_WIDTH-1:0] CNT_LAST = {{(PWM_WIDTH-1){1'b1}}, 1'b0};
  localparam logic                 POL      = (OUTPUT_ACTIVE_LOW != 0);

  logic [7:0]              presc_cnt_q, presc_cnt_d;
  logic [PWM_WIDTH-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [PWM_WIDTH-1:0]    shadow_q [NUM_CHANNELS];
  logic [PWM_WIDTH-1:0]    shadow_d [NUM_CHANNELS];
  logic [PWM_WIDTH-1:0]    active_q [NUM_CHANNELS];
  logic [PWM_WIDTH-1:0]    active_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] led_q, led_d;
  logic                    tick, wrap;

  assign tick = (presc_cnt_q == prescale_i);
  assign wrap = tick && (pwm_cnt_q == CNT_LAST);

  // Next-state for prescaler, PWM counter, duty registers and LED drive.
  always_comb begin
    presc_cnt_d = presc_cnt_q + 8'd1;
    if (prescale_wr_i || tick) presc_cnt_d = 8'd0;

    pwm_cnt_d = pwm_cnt_q;
    if (tick) pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 1'b1;

    // Active duties take the shadow value present before this edge's write,
    // so a write landing on the wrap edge waits for the next wrap.
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (duty_wr_i && (duty_idx_i == 4'(i))) shadow_d[i] = duty_data_i;
      active_d[i] = wrap ? shadow_q[i] : active_q[i];
      led_d[i]    = (enable_i && (pwm_cnt_q < active_q[i])) ^ POL;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      led_q       <= {NUM_CHANNELS{POL}};
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  // Flatten shadow duties for register readback.
  always_comb begin
    shadow_o = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) shadow_o[i*PWM_WIDTH +: PWM_WIDTH] = shadow_q[i];
  end

  assign led_o = led_q;

endmodule

// File: rtl/i2c_led_pwm_regs.sv
// Register bank between i2c_slave and the LED pins: handshake FSM, register
// decode/readback, and the PWM engine instance.
module i2c_led_pwm_regs
  import i2c_led_pkg::*;
#(
  parameter int         NUM_CHANNELS      = 3,
  parameter int         PWM_WIDTH         = 8,
  parameter int         OUTPUT_ACTIVE_LOW = 1,
  parameter logic [7:0] ID_VALUE          = 8'hA5
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [6:0]              reg_address,
  input  logic                    reg_is_write,
  input  logic                    reg_request,
  input  logic [7:0]              reg_write_data,
  output logic                    reg_response,
  output logic [7:0]              reg_read_data,
  output logic [NUM_CHANNELS-1:0] led_out,
  output logic [1:0]              hs_state_dbg
);

  localparam logic [7:0] CAPS_VALUE = {4'(PWM_WIDTH), 4'(NUM_CHANNELS - 1)};

  // Handshake: the requester raises reg_request with address/direction/data
  // stable and holds it until it sees reg_response. A transaction is accepted
  // on the edge where the FSM is IDLE and reg_request is high; reg_response is
  // high for exactly the following cycle; the FSM then waits for reg_request to
  // drop before it can accept again, so one held request yields one ACK.
  hs_state_t state_q, state_d;
  logic      accept;
  logic      wr_en, rd_en;

  logic       ctrl_en_q, ctrl_en_d;
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] rdata_q, rdata_d;

  logic [6:0]                        duty_off;
  logic                              addr_is_duty;
  logic [3:0]                        duty_idx;
  logic [7:0]                        duty_rd;
  logic [NUM_CHANNELS*PWM_WIDTH-1:0] shadow_flat;

  // Handshake state register.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Handshake next-state and accept strobe.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reg_request) begin
          state_d = ACK;
          accept  = 1'b1;
        end
      end
      ACK:          state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!reg_request) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  assign reg_response = (state_q == ACK);
  assign hs_state_dbg = state_q;
  assign wr_en        = accept && reg_is_write;
  assign rd_en        = accept && !reg_is_write;

  assign duty_off     = reg_address - ADDR_DUTY_BASE;
  assign addr_is_duty = (reg_address >= ADDR_DUTY_BASE) && (duty_off < 7'(NUM_CHANNELS));
  assign duty_idx     = duty_off[3:0];

  // Select the shadow duty for readback, zero-extended to a byte.
  always_comb begin
    duty_rd = 8'h00;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (duty_idx == 4'(i)) duty_rd = 8'(shadow_flat[i*PWM_WIDTH +: PWM_WIDTH]);
    end
  end

  // Register writes and read-data capture on the accept edge.
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    prescale_d = prescale_q;
    rdata_d    = rdata_q;
    if (wr_en) begin
      case (reg_address)
        ADDR_CTRL:     ctrl_en_d  = reg_write_data[CTRL_ENABLE_BIT];
        ADDR_PRESCALE: prescale_d = reg_write_data;
        default:       ;
      endcase
    end
    if (rd_en) begin
      case (reg_address)
        ADDR_ID:       rdata_d = ID_VALUE;
        ADDR_CTRL:     rdata_d = {7'b0, ctrl_en_q};
        ADDR_CAPS:     rdata_d = CAPS_VALUE;
        ADDR_PRESCALE: rdata_d = prescale_q;
        default:       rdata_d = addr_is_duty ? duty_rd : 8'h00;
      endcase
    end
  end

  // Control/status registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ctrl_en_q  <= 1'b0;
      prescale_q <= 8'h00;
      rdata_q    <= 8'h00;
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      prescale_q <= prescale_d;
      rdata_q    <= rdata_d;
    end
  end

  assign reg_read_data = rdata_q;

  led_pwm_core #(
    .NUM_CHANNELS      (NUM_CHANNELS),
    .PWM_WIDTH         (PWM_WIDTH),
    .OUTPUT_ACTIVE_LOW (OUTPUT_ACTIVE_LOW)
  ) u_core (
    .clock         (clock),
    .resetn        (resetn),
    .enable_i      (ctrl_en_q),
    .prescale_i    (prescale_q),
    .prescale_wr_i (wr_en && (reg_address == ADDR_PRESCALE)),
    .duty_wr_i     (wr_en && addr_is_duty),
    .duty_idx_i    (duty_idx),
    .duty_data_i   (reg_write_data[PWM_WIDTH-1:0]),
    .shadow_o      (shadow_flat),
    .led_o         (led_out)
  );

endmodule

// File: tb/tb_i2c_led_pwm_regs.sv
// Testbench for i2c_led_pwm_regs with default parameters (3 channels,
// 8-bit PWM, active-low outputs, ID 0xA5).
module tb_i2c_led_pwm_regs;

  localparam int NCH    = 3;
  localparam int PERIOD = 255;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] reg_address = '0;
  logic       reg_is_write = 1'b0;
  logic       reg_request = 1'b0;
  logic [7:0] reg_write_data = '0;
  logic       reg_response;
  logic [7:0] reg_read_data;
  logic [NCH-1:0] led_out;
  logic [1:0] hs_state_dbg;

  always #5 clock = ~clock;

  i2c_led_pwm_regs dut (
    .clock          (clock),
    .resetn         (resetn),
    .reg_address    (reg_address),
    .reg_is_write   (reg_is_write),
    .reg_request    (reg_request),
    .reg_write_data (reg_write_data),
    .reg_response   (reg_response),
    .reg_read_data  (reg_read_data),
    .led_out        (led_out),
    .hs_state_dbg   (hs_state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Time-based view: the PWM counter is (ticks so far) mod 255, a tick occurs
  // when clocks since the last prescale restart reach a multiple of PRESCALE+1.
  int m_en, m_presc, m_hs, m_clk, m_ticks, m_cnt;
  int m_shadow [NCH];
  int m_active [NCH];
  logic           exp_resp;
  logic [7:0]     exp_rdata;
  logic [NCH-1:0] exp_led;
  int mt_cnt, mt_a;
  logic mt_tick, mt_wrap, mt_commit;
  int mt_old [NCH];

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a == 7'h00) return 8'hA5;
    if (a == 7'h01) return 8'(m_en);
    if (a == 7'h02) return 8'h82;
    if (a == 7'h03) return 8'(m_presc);
    if (a >= 7'h10 && int'(a) < 16 + NCH) return 8'(m_shadow[int'(a) - 16]);
    return 8'h00;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      m_en = 0; m_presc = 0; m_hs = 0; m_clk = 0; m_ticks = 0; m_cnt = 0;
      for (int i = 0; i < NCH; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      exp_resp = 1'b0; exp_rdata = 8'h00; exp_led = '1;
    end else begin
      mt_cnt  = m_ticks % PERIOD;
      mt_tick = ((m_clk % (m_presc + 1)) == m_presc);
      mt_wrap = mt_tick && (mt_cnt == PERIOD - 1);
      for (int i = 0; i < NCH; i++) begin
        exp_led[i] = (m_en != 0 && mt_cnt < m_active[i]) ? 1'b0 : 1'b1;
        mt_old[i]  = m_shadow[i];
      end
      mt_commit = (m_hs == 0) && reg_request;
      exp_resp  = mt_commit;
      if (m_hs == 0) begin if (reg_request) m_hs = 1; end
      else if (m_hs == 1) m_hs = 2;
      else if (!reg_request) m_hs = 0;
      if (mt_wrap) for (int i = 0; i < NCH; i++) m_active[i] = mt_old[i];
      if (mt_tick) m_ticks++;
      if (mt_commit && reg_is_write && reg_address == 7'h03) m_clk = 0;
      else m_clk++;
      if (mt_commit && !reg_is_write) exp_rdata = model_read(reg_address);
      if (mt_commit && reg_is_write) begin
        mt_a = int'(reg_address);
        if (mt_a == 1) m_en = int'(reg_write_data[0]);
        else if (mt_a == 3) m_presc = int'(reg_write_data);
        else if (mt_a >= 16 && mt_a < 16 + NCH) m_shadow[mt_a - 16] = int'(reg_write_data);
      end
      m_cnt = m_ticks % PERIOD;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("reg_response", 32'(reg_response), 32'(exp_resp));
      check("reg_read_data", 32'(reg_read_data), 32'(exp_rdata));
      check("led_out", 32'(led_out), 32'(exp_led));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic xfer(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                      input int hold, output logic [7:0] rdata, output int acks, output int lat);
    reg_is_write   = wr;
    reg_address    = addr;
    reg_write_data = wdata;
    reg_request    = 1'b1;
    acks = 0; lat = -1; rdata = 8'h00;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clock);
      if (reg_response) begin lat = c; acks = 1; rdata = reg_read_data; end
    end
    if (lat < 0) fail_now("ack_timeout");
    repeat (hold) begin
      @(negedge clock);
      if (reg_response) acks++;
    end
    reg_request = 1'b0;
    @(negedge clock);
    if (reg_response) acks++;
    @(negedge clock);
  endtask

  task automatic wr(input logic [6:0] addr, input logic [7:0] data);
    logic [7:0] rd; int acks, lat;
    xfer(1'b1, addr, data, 0, rd, acks, lat);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] addr, input logic [7:0] exp);
    logic [7:0] rd; int acks, lat;
    exp_q.push_back(exp);
    xfer(1'b0, addr, 8'h00, 0, rd, acks, lat);
    check(name, 32'(rd), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_cnt(input int target);
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (m_cnt == target) return;
    end
    fail_now("wait_cnt");
  endtask

  task automatic count_low(input int ch, input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clock);
      if (led_out[ch] == 1'b0) lows++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd;
    int acks, lat, lows;

    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("reset_resp", 32'(reg_response), 32'd0);
    check("reset_rdata", 32'(reg_read_data), 32'h00);
    check("reset_led", 32'(led_out), 32'b111);
    resetn = 1'b1;
    @(negedge clock);

    // ID / CAPS defaults, ACK timing
    xfer(1'b0, 7'h00, 8'h00, 0, rd, acks, lat);
    check("id_value", 32'(rd), 32'hA5);
    check("id_latency", 32'(lat), 32'd1);
    check("id_acks", 32'(acks), 32'd1);
    rd_chk("caps_value", 7'h02, 8'h82);
    rd_chk("ctrl_default", 7'h01, 8'h00);

    // 50% duty on channel 0
    wr(7'h01, 8'h01);
    wr(7'h03, 8'h00);
    wr(7'h10, 8'h80);
    wait_cnt(0);
    wait_cnt(200);
    count_low(0, PERIOD, lows);
    check("duty80_lit_clocks", 32'(lows), 32'd128);

    // constant off / constant on
    wr(7'h11, 8'h00);
    wr(7'h12, 8'hFF);
    wait_cnt(0);
    wait_cnt(5);
    count_low(1, 3 * PERIOD, lows);
    check("duty00_lit_clocks", 32'(lows), 32'd0);
    wait_cnt(0);
    wait_cnt(5);
    count_low(2, 3 * PERIOD, lows);
    check("dutyFF_lit_clocks", 32'(lows), 32'(3 * PERIOD));

    // mid-period change: current period keeps 128, next uses 16
    wait_cnt(50);
    wr(7'h10, 8'h10);
    wait_cnt(120);
    check("midperiod_old_duty", 32'(led_out[0]), 32'd0);
    wait_cnt(200);
    count_low(0, PERIOD, lows);
    check("duty10_lit_clocks", 32'(lows), 32'd16);

    // write landing on the wrap edge is deferred one period
    wait_cnt(254);
    wr(7'h10, 8'h40);
    wait_cnt(30);
    check("wrapwrite_deferred", 32'(led_out[0]), 32'd1);
    wait_cnt(200);
    count_low(0, PERIOD, lows);
    check("duty40_lit_clocks", 32'(lows), 32'd64);

    // slower prescaler, then back to full speed
    wr(7'h03, 8'h02);
    rd_chk("prescale_rb", 7'h03, 8'h02);
    repeat (300) @(negedge clock);
    wr(7'h03, 8'h00);

    // unmapped / read-only / ignored bits
    rd_chk("unmapped_7f", 7'h7F, 8'h00);
    wr(7'h7F, 8'hFF);
    wr(7'h13, 8'h55);
    rd_chk("unmapped_13", 7'h13, 8'h00);
    wr(7'h00, 8'h12);
    rd_chk("id_ro", 7'h00, 8'hA5);
    wr(7'h02, 8'h00);
    rd_chk("caps_ro", 7'h02, 8'h82);
    rd_chk("duty0_rb", 7'h10, 8'h40);
    wr(7'h01, 8'hFE);
    rd_chk("ctrl_bit0_only", 7'h01, 8'h00);
    repeat (20) @(negedge clock);
    check("disabled_led", 32'(led_out), 32'b111);
    wr(7'h01, 8'hFF);
    rd_chk("ctrl_enable_rb", 7'h01, 8'h01);

    // held request -> single ACK
    xfer(1'b0, 7'h00, 8'h00, 10, rd, acks, lat);
    check("held_req_acks", 32'(acks), 32'd1);

    // reset during ACK
    wr(7'h10, 8'hFF);
    wait_cnt(0);
    wait_cnt(5);
    check("ffduty_lit", 32'(led_out[0]), 32'd0);
    reg_is_write = 1'b0;
    reg_address  = 7'h10;
    reg_request  = 1'b1;
    @(negedge clock);
    check("pre_reset_ack", 32'(reg_response), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    check("midreset_resp", 32'(reg_response), 32'd0);
    check("midreset_led", 32'(led_out), 32'b111);
    resetn = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (reg_response) acks++;
    end
    check("post_reset_acks", 32'(acks), 32'd1);
    reg_request = 1'b0;
    repeat (2) @(negedge clock);
    rd_chk("duty0_after_reset", 7'h10, 8'h00);
    rd_chk("ctrl_after_reset", 7'h01, 8'h00);

    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
